// File: rtl/cpipe2_issue.sv
// Purpose: stage-2 control-word generator; expands loads to two words, pads returns with NIL bubbles.
// Latency: one cycle from accepted opcode to the registered cpipe2s word.
// Backpressure: op_ready drops during LDWB/NIL expansion, under stall2 or flush, and while in reset.
module cpipe2_issue #(
    parameter int           RET_NIL_CYCLES = 2,
    parameter logic [5:0]   LOAD_WB_CODE   = 6'b110001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [5:0]  op_word,
    input  logic        stall2,
    input  logic        flush,
    output logic [7:0]  cpipe2s,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LDWB = 2'd1,
        S_NIL  = 2'd2
    } state_t;

    localparam logic [3:0] NIL_LOAD = 4'(RET_NIL_CYCLES);

    state_t      r_state;
    logic [3:0]  r_nil_cnt;
    logic [7:0]  r_cpipe2s;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [3:0]  w_nil_cnt_nxt;
    logic [7:0]  w_cpipe2s_nxt;
    logic        w_busy_nxt;
    logic        w_xfer;
    logic        w_is_load;
    logic        w_is_ret;

    // Accept only in RUN, never when frozen or being flushed, and never while reset is held.
    assign op_ready  = rst_n & (r_state == S_RUN) & ~stall2 & ~flush;
    assign w_xfer    = op_valid & op_ready;
    assign w_is_load = (op_word == 6'b110000);
    assign w_is_ret  = (op_word[5:4] == 2'b00) & op_word[3] & op_word[1];

    assign cpipe2s = r_cpipe2s;
    assign busy    = r_busy;

    // Next-state and next-word decode: flush beats stall2, stall2 beats the state action.
    always_comb begin
        w_state_nxt   = r_state;
        w_nil_cnt_nxt = r_nil_cnt;
        w_cpipe2s_nxt = r_cpipe2s;
        w_busy_nxt    = r_busy;
        if (flush) begin
            w_state_nxt   = S_RUN;
            w_nil_cnt_nxt = 4'd0;
            w_cpipe2s_nxt = 8'h00;
            w_busy_nxt    = 1'b0;
        end else if (!stall2) begin
            case (r_state)
                S_RUN: begin
                    if (w_xfer) begin
                        w_cpipe2s_nxt = {2'b10, op_word};
                        if (w_is_load) begin
                            w_state_nxt = S_LDWB;
                        end else if (w_is_ret && (RET_NIL_CYCLES > 0)) begin
                            w_state_nxt   = S_NIL;
                            w_nil_cnt_nxt = NIL_LOAD;
                        end
                    end else begin
                        w_cpipe2s_nxt = 8'h00;
                    end
                end
                S_LDWB: begin
                    w_cpipe2s_nxt = {2'b10, LOAD_WB_CODE};
                    w_state_nxt   = S_RUN;
                end
                S_NIL: begin
                    w_cpipe2s_nxt = 8'h00;
                    // Counter is >=1 whenever NIL is entered; the guard keeps it from wrapping regardless.
                    if (r_nil_cnt != 4'd0) begin
                        w_nil_cnt_nxt = r_nil_cnt - 4'd1;
                    end
                    if (r_nil_cnt <= 4'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt   = S_RUN;
                    w_nil_cnt_nxt = 4'd0;
                    w_cpipe2s_nxt = 8'h00;
                end
            endcase
            w_busy_nxt = (w_state_nxt != S_RUN);
        end
    end

    // State, counter and output word registers; reset abandons any expansion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_nil_cnt <= 4'd0;
            r_cpipe2s <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_nil_cnt <= w_nil_cnt_nxt;
            r_cpipe2s <= w_cpipe2s_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_cpipe2_issue.sv
// Purpose: directed bench for cpipe2_issue covering issue, load expansion, return bubbles, stall, flush, reset.
// Latency: outputs sampled 1 ns after each rising edge; inputs changed at that same point.
// Backpressure: op_ready is compared against hand-derived values in every scenario.
module tb_cpipe2_issue;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [5:0] op_word;
    logic       stall2;
    logic       flush;
    logic [7:0] cpipe2s;
    logic       busy;

    int checks;
    int errors;

    cpipe2_issue #(
        .RET_NIL_CYCLES (2),
        .LOAD_WB_CODE   (6'b110001)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_word  (op_word),
        .stall2   (stall2),
        .flush    (flush),
        .cpipe2s  (cpipe2s),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op_valid = 1'b1; op_word = 6'h05; stall2 = 1'b0; flush = 1'b0;
        #12;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL reset_cpipe got %h want 00", cpipe2s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", op_ready); end
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL idle_bubble got %h want 00", cpipe2s); end
    endtask

    task automatic test_steady_issue;
        op_valid = 1'b1; op_word = 6'h05;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL issue_ready0 got %b want 1", op_ready); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (cpipe2s !== 8'h85) begin errors++; $display("FAIL issue_c%0d got %h want 85", i, cpipe2s); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL issue_busy%0d got %b want 0", i, busy); end
            checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL issue_ready%0d got %b want 1", i, op_ready); end
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] words [4];
        logic [7:0] exp   [4];
        words[0] = 6'h12; exp[0] = 8'h92;
        words[1] = 6'h3F; exp[1] = 8'hBF;
        words[2] = 6'h21; exp[2] = 8'hA1;
        words[3] = 6'h05; exp[3] = 8'h85;
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1; op_word = words[i];
            tick;
            checks++; if (cpipe2s !== exp[i]) begin errors++; $display("FAIL b2b_%0d got %h want %h", i, cpipe2s, exp[i]); end
        end
        op_valid = 1'b0;
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL b2b_bubble got %h want 00", cpipe2s); end
    endtask

    task automatic test_load;
        op_valid = 1'b1; op_word = 6'h30;
        tick;
        op_word = 6'h05;
        #1;
        checks++; if (cpipe2s !== 8'hB0) begin errors++; $display("FAIL load_w1 got %h want B0", cpipe2s); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b want 0", op_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy); end
        tick;
        checks++; if (cpipe2s !== 8'hB1) begin errors++; $display("FAIL load_w2 got %h want B1", cpipe2s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy2 got %b want 0", busy); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL load_ready2 got %b want 1", op_ready); end
        tick;
        checks++; if (cpipe2s !== 8'h85) begin errors++; $display("FAIL load_next got %h want 85", cpipe2s); end
        op_valid = 1'b0;
        tick;
    endtask

    task automatic test_return;
        op_valid = 1'b1; op_word = 6'h0A;
        tick;
        op_word = 6'h05;
        #1;
        checks++; if (cpipe2s !== 8'h8A) begin errors++; $display("FAIL ret_word got %h want 8A", cpipe2s); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL ret_ready0 got %b want 0", op_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ret_busy0 got %b want 1", busy); end
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL ret_nil1 got %h want 00", cpipe2s); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL ret_ready1 got %b want 0", op_ready); end
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL ret_nil2 got %h want 00", cpipe2s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ret_busy2 got %b want 0", busy); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL ret_ready2 got %b want 1", op_ready); end
        tick;
        checks++; if (cpipe2s !== 8'h85) begin errors++; $display("FAIL ret_next got %h want 85", cpipe2s); end
        op_valid = 1'b0;
        tick;
    endtask

    task automatic test_stall_ldwb;
        op_valid = 1'b1; op_word = 6'h30;
        tick;
        op_valid = 1'b0; stall2 = 1'b1;
        #1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", op_ready); end
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (cpipe2s !== 8'hB0) begin errors++; $display("FAIL stall_hold%0d got %h want B0", i, cpipe2s); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy%0d got %b want 1", i, busy); end
        end
        stall2 = 1'b0;
        tick;
        checks++; if (cpipe2s !== 8'hB1) begin errors++; $display("FAIL stall_resume got %h want B1", cpipe2s); end
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL stall_after got %h want 00", cpipe2s); end
    endtask

    task automatic test_flush_nil;
        op_valid = 1'b1; op_word = 6'h0A;
        tick;
        op_valid = 1'b0;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b want 1", busy); end
        stall2 = 1'b1; flush = 1'b1; op_valid = 1'b1; op_word = 6'h05;
        #1;
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", op_ready); end
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL flush_cpipe got %h want 00", cpipe2s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        stall2 = 1'b0; flush = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got %b want 1", op_ready); end
        tick;
        checks++; if (cpipe2s !== 8'h85) begin errors++; $display("FAIL flush_next got %h want 85", cpipe2s); end
        // Flush in RUN with a valid op: nothing accepted, word cleared.
        flush = 1'b1;
        tick;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL flush_run got %h want 00", cpipe2s); end
        flush = 1'b0; op_valid = 1'b0;
        tick;
    endtask

    task automatic test_async_reset;
        op_valid = 1'b1; op_word = 6'h30;
        tick;
        op_valid = 1'b0;
        checks++; if (cpipe2s !== 8'hB0) begin errors++; $display("FAIL arst_pre got %h want B0", cpipe2s); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL arst_now got %h want 00", cpipe2s); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++; if (cpipe2s !== 8'h00) begin errors++; $display("FAIL arst_after%0d got %h want 00", i, cpipe2s); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_steady_issue;
        test_back_to_back;
        test_load;
        test_return;
        test_stall_ldwb;
        test_flush_nil;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
